// File: rtl/fb_pkg.sv
// Shared constants and write-port state encoding for the frame-buffer port controller.
package fb_pkg;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned IMG_W  = 320;
    localparam int unsigned IMG_H  = 240;
    localparam int unsigned DEPTH  = IMG_W * IMG_H;
    localparam int unsigned RD_LAT = 1;

    typedef enum logic [1:0] {
        W_CLEAR   = 2'd0,
        W_WAIT    = 2'd1,
        W_CAPTURE = 2'd2
    } wr_state_e;

endpackage

// File: rtl/fb_rd_scan.sv
// Read-port scan: sequential address generator plus a valid strobe aligned to the
// register stage and the RAM read latency.
module fb_rd_scan
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W = fb_pkg::ADDR_W,
    parameter int unsigned DEPTH  = fb_pkg::DEPTH,
    parameter int unsigned RD_LAT = fb_pkg::RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_start,
    input  logic              rd_en,
    input  logic              ram_dout,
    output logic              ram_ceb,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              rd_valid,
    output logic              rd_pix
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] adb_q;
    logic [ADDR_W-1:0] base;
    logic [RD_LAT:0]   vld_q;

    // rd_start takes effect in its own cycle so a coincident rd_en reads address 0
    always_comb base = rd_start ? '0 : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            adb_q  <= '0;
            vld_q  <= '0;
        end else begin
            vld_q[0] <= rd_en;
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (rd_en) begin
                adb_q  <= base;
                addr_q <= (base == LAST) ? '0 : base + ADDR_W'(1);
            end else begin
                addr_q <= base;
            end
        end
    end

    assign ram_ceb  = vld_q[0];
    assign ram_adb  = adb_q;
    assign rd_valid = vld_q[RD_LAT];
    assign rd_pix   = rd_valid & ram_dout;

endmodule

// File: rtl/fb_port_ctrl.sv
// Frame-buffer port sequencer: clear engine and camera capture share the write port,
// fb_rd_scan drives the read port for LCD scan-out.
module fb_port_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W = fb_pkg::ADDR_W,
    parameter int unsigned IMG_W  = fb_pkg::IMG_W,
    parameter int unsigned IMG_H  = fb_pkg::IMG_H,
    parameter int unsigned DEPTH  = IMG_W * IMG_H,
    parameter int unsigned RD_LAT = fb_pkg::RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    input  logic              cam_frame_start,
    input  logic              cam_pix_valid,
    input  logic              cam_pix,
    input  logic              rd_start,
    input  logic              rd_en,
    output logic              rd_pix,
    output logic              rd_valid,
    output logic              busy_clear,
    output logic              frame_done,
    output logic              cam_overrun,
    output logic              ram_cea,
    output logic [ADDR_W-1:0] ram_ada,
    output logic              ram_din,
    output logic              ram_ceb,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              ram_oce,
    input  logic              ram_dout
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic [ADDR_W-1:0] cap_addr_w;
    logic [ADDR_W-1:0] ada_d;
    logic              cea_d, din_d;
    logic              fd_q, fd_d;
    logic              ovr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= W_CLEAR;
            clr_cnt_q   <= '0;
            cap_addr_q  <= '0;
            ram_cea     <= 1'b0;
            ram_ada     <= '0;
            ram_din     <= 1'b0;
            fd_q        <= 1'b0;
            frame_done  <= 1'b0;
            cam_overrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            cap_addr_q  <= cap_addr_d;
            ram_cea     <= cea_d;
            ram_ada     <= ada_d;
            ram_din     <= din_d;
            fd_q        <= fd_d;
            frame_done  <= fd_q;
            cam_overrun <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        cap_addr_d = cap_addr_q;
        cea_d      = 1'b0;
        ada_d      = ram_ada;
        din_d      = ram_din;
        fd_d       = 1'b0;
        ovr_d      = cam_overrun;
        // a frame start redirects the coincident pixel to address 0
        cap_addr_w = cam_frame_start ? '0 : cap_addr_q;

        if (clear_req) begin
            state_d   = W_CLEAR;
            clr_cnt_d = '0;
            ovr_d     = 1'b0;
        end else begin
            case (state_q)
                W_CLEAR: begin
                    cea_d = 1'b1;
                    ada_d = clr_cnt_q;
                    din_d = 1'b0;
                    if (clr_cnt_q == LAST) begin
                        state_d   = W_WAIT;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                    if (cam_pix_valid) ovr_d = 1'b1;
                end
                W_WAIT, W_CAPTURE: begin
                    if (cam_frame_start) begin
                        state_d    = W_CAPTURE;
                        cap_addr_d = '0;
                    end
                    if (cam_pix_valid) begin
                        if (cam_frame_start || state_q == W_CAPTURE) begin
                            cea_d = 1'b1;
                            ada_d = cap_addr_w;
                            din_d = cam_pix;
                            if (cap_addr_w == LAST) begin
                                fd_d       = 1'b1;
                                state_d    = W_WAIT;
                                cap_addr_d = '0;
                            end else begin
                                cap_addr_d = cap_addr_w + ADDR_W'(1);
                            end
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end
                default: state_d = W_CLEAR;
            endcase
        end
    end

    assign busy_clear = (state_q == W_CLEAR);
    assign ram_oce    = 1'b1;

    fb_rd_scan #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) u_rd_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_start (rd_start),
        .rd_en    (rd_en),
        .ram_dout (ram_dout),
        .ram_ceb  (ram_ceb),
        .ram_adb  (ram_adb),
        .rd_valid (rd_valid),
        .rd_pix   (rd_pix)
    );

endmodule
